// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the single-byte I2C master controller:
//   - state_t      : controller state encoding
//   - Q0..Q3       : quarter-of-bit-slot indices
//   - BIT_CNT_W    : width of the per-byte bit counter
//   - ACK / NACK   : SDA level seen in the acknowledge slot
//   - bit_to_oe()  : converts a bus bit to the open-drain pull-low enable
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WDATA    = 4'd4,
        ST_WACK     = 4'd5,
        ST_RDATA    = 4'd6,
        ST_RNACK    = 4'd7,
        ST_STOP     = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = 4'd7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // A 1 on an open-drain line is produced by releasing it.
    function automatic logic bit_to_oe(input logic b);
        return (b == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// i2c_master_ctrl_if
// Host request/response signals plus the open-drain pin controls.
//   Host side : start, rw, dev_addr[6:0], wr_data[7:0]  -> controller
//               busy, done, ack_err, rd_data[7:0]        <- controller
//   Pin side  : sda_in                                   -> controller
//               scl_oe, sda_oe (1 = pull low)            <- controller
// Modport master is the controller view; slave is the surrounding logic.
// ---------------------------------------------------------------------------
interface i2c_master_ctrl_if;

    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] wr_data;
    logic       sda_in;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rd_data;
    logic       scl_oe;
    logic       sda_oe;

    modport master (
        input  start, rw, dev_addr, wr_data, sda_in,
        output busy, done, ack_err, rd_data, scl_oe, sda_oe
    );

    modport slave (
        output start, rw, dev_addr, wr_data, sda_in,
        input  busy, done, ack_err, rd_data, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_quarter_tick.sv
// ---------------------------------------------------------------------------
// i2c_quarter_tick
// Divides ref_clk into quarter-bit periods.
//   ref_clk : clock
//   reset   : asynchronous, active-low
//   en      : count while high, counter held at 0 while low
//   tick    : one-cycle pulse on the last cycle of every CLK_DIV-cycle quarter
// ---------------------------------------------------------------------------
module i2c_quarter_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic ref_clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Holding the counter at 0 while idle makes the first quarter after an
    // accept exactly CLK_DIV cycles long.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_ctrl
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK,
// STOP, driven on open-drain SCL/SDA from one clock domain.
//   ref_clk : clock (rising edge)
//   reset   : asynchronous, active-low; releases both lines immediately
//   bus     : i2c_master_ctrl_if.master (host handshake + pin controls)
// CLK_DIV is the number of ref_clk cycles per quarter SCL period (>= 2).
// ---------------------------------------------------------------------------
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic                      ref_clk,
    input  logic                      reset,
    i2c_master_ctrl_if.master         bus
);

    import i2c_pkg::*;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           qtr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shreg;
    logic                 rw_q;
    logic [7:0]           wdata_q;
    logic                 ack_err_q;
    logic [7:0]           rd_data_q;
    logic                 busy_w;
    logic                 tick;
    logic                 slot_end;
    logic                 sample;
    logic                 scl_oe_w;
    logic                 sda_oe_w;

    assign busy_w   = (state != ST_IDLE) && (state != ST_DONE);
    assign slot_end = tick && (qtr == Q3);
    assign sample   = tick && (qtr == Q1);

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .ref_clk (ref_clk),
        .reset   (reset),
        .en      (busy_w),
        .tick    (tick)
    );

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot transitions happen only at the end of q3; SCL/SDA levels are a
    // pure decode of state, quarter and the outgoing shift-register MSB, so
    // SDA moves only when those registers do.
    always_comb begin
        state_nxt = state;
        scl_oe_w  = 1'b0;
        sda_oe_w  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_START;
            end
            ST_START: begin
                sda_oe_w = (qtr == Q2) || (qtr == Q3);
                if (slot_end) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                scl_oe_w = (qtr == Q0) || (qtr == Q3);
                sda_oe_w = bit_to_oe(shreg[7]);
                if (slot_end && bit_cnt == LAST_BIT) state_nxt = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
                scl_oe_w = (qtr == Q0) || (qtr == Q3);
                if (slot_end) begin
                    if (ack_err_q)  state_nxt = ST_STOP;
                    else if (rw_q)  state_nxt = ST_RDATA;
                    else            state_nxt = ST_WDATA;
                end
            end
            ST_WDATA: begin
                scl_oe_w = (qtr == Q0) || (qtr == Q3);
                sda_oe_w = bit_to_oe(shreg[7]);
                if (slot_end && bit_cnt == LAST_BIT) state_nxt = ST_WACK;
            end
            ST_WACK: begin
                scl_oe_w = (qtr == Q0) || (qtr == Q3);
                if (slot_end) state_nxt = ST_STOP;
            end
            ST_RDATA: begin
                scl_oe_w = (qtr == Q0) || (qtr == Q3);
                if (slot_end && bit_cnt == LAST_BIT) state_nxt = ST_RNACK;
            end
            ST_RNACK: begin
                scl_oe_w = (qtr == Q0) || (qtr == Q3);
                if (slot_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                scl_oe_w = (qtr == Q0);
                sda_oe_w = (qtr != Q3);
                if (slot_end) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: request latch, quarter/bit counters, shift register and the
    // sticky result registers. The shift register carries the outgoing
    // address and write byte (shifted at slot end) and collects the read
    // byte (shifted at the q1 sample point).
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            qtr       <= Q0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            ack_err_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (state == ST_IDLE) begin
                qtr <= Q0;
                if (bus.start) begin
                    rw_q      <= bus.rw;
                    wdata_q   <= bus.wr_data;
                    shreg     <= {bus.dev_addr, bus.rw};
                    bit_cnt   <= '0;
                    ack_err_q <= 1'b0;
                end
            end else if (tick) begin
                qtr <= qtr + 2'd1;
            end

            if (sample) begin
                case (state)
                    ST_ADDR_ACK, ST_WACK: begin
                        if (bus.sda_in == NACK) ack_err_q <= 1'b1;
                    end
                    ST_RDATA: begin
                        shreg <= {shreg[6:0], bus.sda_in};
                    end
                    default: begin
                    end
                endcase
            end

            if (slot_end) begin
                case (state)
                    ST_ADDR, ST_WDATA: begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                    ST_ADDR_ACK: begin
                        shreg   <= wdata_q;
                        bit_cnt <= '0;
                    end
                    ST_RDATA: begin
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                    ST_STOP: begin
                        // Only a read that got past the address phase has a byte.
                        if (rw_q && !ack_err_q) rd_data_q <= shreg;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.busy    = busy_w;
    assign bus.done    = (state == ST_DONE);
    assign bus.ack_err = ack_err_q;
    assign bus.rd_data = rd_data_q;
    assign bus.scl_oe  = scl_oe_w;
    assign bus.sda_oe  = sda_oe_w;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_ctrl
// Drives i2c_master_ctrl (CLK_DIV=4) against an open-drain slave model.
// Expected results of each transaction are queued when it is issued; a
// monitor pops and compares them whenever done is asserted.
// ---------------------------------------------------------------------------
module tb_i2c_master_ctrl;

    localparam int CLK_DIV = 4;

    typedef struct {
        string name;
        int    lat;
        int    ack_err;
        int    chk_rd;
        int    rd;
        int    pulses;
        int    addr_byte;
        int    ack8;
        int    data_byte;
        int    bit17;
    } exp_t;

    logic ref_clk = 1'b0;
    logic reset   = 1'b0;

    i2c_master_ctrl_if bus ();

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bus     (bus.master)
    );

    always #5 ref_clk = ~ref_clk;

    // Open-drain wiring: a line is low whenever anybody pulls it.
    logic slave_pull = 1'b0;
    logic sda_line;
    logic scl_line;
    assign sda_line   = !(bus.sda_oe || slave_pull);
    assign scl_line   = !bus.scl_oe;
    assign bus.sda_in = sda_line;

    logic       slave_present  = 1'b1;
    logic       slave_data_ack = 1'b1;
    logic [7:0] slave_rd_byte  = 8'h00;

    int   pulse_cnt = 0;
    logic bits [0:31];
    logic sda_prev = 1'b1;
    logic scl_prev = 1'b1;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Slave / bus monitor: START resets the SCL pulse count, each SCL rise
    // records SDA, each SCL fall decides what the slave drives next.
    always @(sda_line or scl_line) begin
        if (scl_line && scl_prev && !sda_line && sda_prev) begin
            pulse_cnt  = 0;
            slave_pull = 1'b0;
        end else if (scl_line && !scl_prev) begin
            if (pulse_cnt < 32) bits[pulse_cnt] = sda_line;
            pulse_cnt++;
        end else if (!scl_line && scl_prev) begin
            slave_pull = 1'b0;
            if (slave_present) begin
                if (pulse_cnt == 8)
                    slave_pull = 1'b1;
                else if (pulse_cnt >= 9 && pulse_cnt <= 16 && bits[7])
                    slave_pull = !slave_rd_byte[16 - pulse_cnt];
                else if (pulse_cnt == 17 && !bits[7] && slave_data_ack)
                    slave_pull = 1'b1;
            end
        end
        sda_prev = sda_line;
        scl_prev = scl_line;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor_loop();
        int   cyc    = 0;
        int   t0     = 0;
        logic busy_q = 1'b0;
        logic [7:0] ab;
        logic [7:0] db;
        exp_t e;
        forever begin
            @(negedge ref_clk);
            cyc++;
            if (bus.busy && !busy_q) t0 = cyc;
            busy_q = bus.busy;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        ab[7-i] = bits[i];
                        db[7-i] = bits[9+i];
                    end
                    check_output({e.name, "_latency"}, cyc - t0, e.lat);
                    check_output({e.name, "_ack_err"}, {31'd0, bus.ack_err}, e.ack_err);
                    check_output({e.name, "_pulses"}, pulse_cnt, e.pulses);
                    check_output({e.name, "_addr_byte"}, {24'd0, ab}, e.addr_byte);
                    check_output({e.name, "_ack_slot"}, {31'd0, bits[8]}, e.ack8);
                    if (e.pulses == 19) begin
                        check_output({e.name, "_data_byte"}, {24'd0, db}, e.data_byte);
                        check_output({e.name, "_bit17"}, {31'd0, bits[17]}, e.bit17);
                    end
                    if (e.chk_rd != 0)
                        check_output({e.name, "_rd_data"}, {24'd0, bus.rd_data}, e.rd);
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic rw_i, input logic [6:0] addr_i, input logic [7:0] wr_i);
        @(negedge ref_clk);
        bus.rw       = rw_i;
        bus.dev_addr = addr_i;
        bus.wr_data  = wr_i;
        bus.start    = 1'b1;
        @(negedge ref_clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge ref_clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            check_output({name, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_txn(input logic rw_i, input logic [6:0] addr_i, input logic [7:0] wr_i, input exp_t e);
        sb.push_back(e);
        apply_stimulus(rw_i, addr_i, wr_i);
        wait_done(e.name);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        bit ok;
        bus.start    = 1'b0;
        bus.rw       = 1'b0;
        bus.dev_addr = 7'h00;
        bus.wr_data  = 8'h00;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge ref_clk);
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_done", {31'd0, bus.done}, 32'd0);
        check_output("rst_lines", {30'd0, bus.scl_oe, bus.sda_oe}, 32'd0);
        check_output("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge ref_clk);

        // name, lat, ack_err, chk_rd, rd, pulses, addr, ack8, data, bit17
        run_txn(1'b0, 7'h50, 8'hA5, '{"write_ack", 320, 0, 0, 0, 19, 8'hA0, 0, 8'hA5, 0});

        slave_rd_byte = 8'h3C;
        run_txn(1'b1, 7'h50, 8'h00, '{"read", 320, 0, 1, 8'h3C, 19, 8'hA1, 0, 8'h3C, 1});

        slave_present = 1'b0;
        run_txn(1'b0, 7'h21, 8'hA5, '{"addr_nack", 176, 1, 0, 0, 10, 8'h42, 1, 0, 0});
        check_output("addr_nack_rd_hold", {24'd0, bus.rd_data}, 32'h3C);

        slave_present  = 1'b1;
        slave_data_ack = 1'b0;
        run_txn(1'b0, 7'h50, 8'h3C, '{"data_nack", 320, 1, 0, 0, 19, 8'hA0, 0, 8'h3C, 1});
        slave_data_ack = 1'b1;

        // start pulsed while busy must be ignored
        sb.push_back('{"mid_start", 320, 0, 0, 0, 19, 8'h54, 0, 8'h81, 0});
        apply_stimulus(1'b0, 7'h2A, 8'h81);
        repeat (40) @(negedge ref_clk);
        apply_stimulus(1'b1, 7'h11, 8'hFF);
        wait_done("mid_start");

        // start in the cycle right after done must be accepted
        sb.push_back('{"b2b", 320, 0, 0, 0, 19, 8'hFE, 0, 8'h00, 0});
        @(negedge ref_clk);
        bus.rw       = 1'b0;
        bus.dev_addr = 7'h7F;
        bus.wr_data  = 8'h00;
        bus.start    = 1'b1;
        @(negedge ref_clk);
        bus.start    = 1'b0;
        check_output("b2b_busy_next", {31'd0, bus.busy}, 32'd1);
        wait_done("b2b");

        // reset during data bit 3 of a write (A5: that bit is 0, SDA pulled)
        apply_stimulus(1'b0, 7'h50, 8'hA5);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge ref_clk);
            if (pulse_cnt == 13 && bus.scl_oe) ok = 1'b1;
        end
        check_output("reset_reach_bit3", {31'd0, ok}, 32'd1);
        check_output("pre_reset_sda_oe", {31'd0, bus.sda_oe}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check_output("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("mid_rst_lines", {30'd0, bus.scl_oe, bus.sda_oe}, 32'd0);
        check_output("mid_rst_ack_err", {31'd0, bus.ack_err}, 32'd0);
        check_output("mid_rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        repeat (3) @(negedge ref_clk);
        reset = 1'b1;
        repeat (4) @(negedge ref_clk);
        check_output("post_rst_idle", {31'd0, bus.busy}, 32'd0);

        run_txn(1'b0, 7'h50, 8'hA5, '{"post_rst_write", 320, 0, 0, 0, 19, 8'hA0, 0, 8'hA5, 0});

        repeat (4) @(negedge ref_clk);
        check_output("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
